// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong game sequencer.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam logic [1:0] TM_TITLE   = 2'b00;
  localparam logic [1:0] TM_PLAY    = 2'b01;
  localparam logic [1:0] TM_NEWBALL = 2'b10;
  localparam logic [1:0] TM_OVER    = 2'b11;

  localparam int unsigned NUM_BALLS_DEF   = 3;
  localparam int unsigned TIMER_TICKS_DEF = 120;
  localparam int unsigned TIMER_W_DEF     = 7;

  // Two-digit BCD increment, wrapping 99 -> 00; returns {tens, units}.
  function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] n1;
    logic [3:0] n0;
    n1 = d1;
    n0 = d0 + 4'd1;
    if (d0 == 4'd9) begin
      n0 = 4'd0;
      n1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
    end
    return {n1, n0};
  endfunction

endpackage

// File: rtl/pong_timer.sv
// Frame-based delay timer: load on start, count refr_tick periods down to zero.
module pong_timer #(
  parameter int unsigned TIMER_W     = 7,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic done
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(TIMER_TICKS - 1);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  // Next count: a start wins over a coincident tick; count stops at zero.
  always_comb begin
    timer_d = timer_q;
    if (start) begin
      timer_d = LOAD_VAL;
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign done = (timer_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/wait/over FSM, ball counter and BCD score.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = NUM_BALLS_DEF,
  parameter int unsigned TIMER_TICKS = TIMER_TICKS_DEF,
  parameter int unsigned TIMER_W     = TIMER_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       graph_still,
  output logic [1:0] text_mode,
  output logic [1:0] balls_left,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic       game_over
);

  localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);

  state_e     state_q, state_d;
  logic [1:0] balls_q, balls_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic       timer_start;
  logic       timer_done;
  logic       pressed;

  assign pressed = |btn;

  pong_timer #(
    .TIMER_W     (TIMER_W),
    .TIMER_TICKS (TIMER_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (timer_start),
    .tick  (refr_tick),
    .done  (timer_done)
  );

  // Next state, ball count, score and timer start.
  always_comb begin
    state_d     = state_q;
    balls_d     = balls_q;
    d1_d        = d1_q;
    d0_d        = d0_q;
    timer_start = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        if (pressed) begin
          state_d = ST_PLAY;
          balls_d = balls_q - 2'd1;
          d1_d    = 4'd0;
          d0_d    = 4'd0;
        end
      end
      ST_PLAY: begin
        if (miss) begin
          timer_start = 1'b1;
          state_d     = (balls_q == 2'd0) ? ST_OVER : ST_NEWBALL;
        end else if (hit) begin
          {d1_d, d0_d} = bcd_inc(d1_q, d0_q);
        end
      end
      ST_NEWBALL: begin
        if (timer_done && pressed) begin
          state_d = ST_PLAY;
          balls_d = balls_q - 2'd1;
        end
      end
      ST_OVER: begin
        if (timer_done) begin
          state_d = ST_NEWGAME;
          balls_d = BALLS_INIT;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  // Registered game state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      balls_q <= BALLS_INIT;
      d1_q    <= '0;
      d0_q    <= '0;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
    end
  end

  // Display controls decoded from the registered state.
  always_comb begin
    graph_still = 1'b1;
    game_over   = 1'b0;
    text_mode   = TM_TITLE;
    case (state_q)
      ST_PLAY: begin
        graph_still = 1'b0;
        text_mode   = TM_PLAY;
      end
      ST_NEWBALL: text_mode = TM_NEWBALL;
      ST_OVER: begin
        text_mode = TM_OVER;
        game_over = 1'b1;
      end
      default: text_mode = TM_TITLE;
    endcase
  end

  assign balls_left = balls_q;
  assign score_d1   = d1_q;
  assign score_d0   = d0_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: table vectors, directed game flow, random play.
module tb_pong_game_ctrl;

  localparam int TICKS = 120;
  localparam int NB    = 3;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       graph_still;
  logic [1:0] text_mode;
  logic [1:0] balls_left;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 title, 1 play, 2 waiting for new ball, 3 game over.
  int m_phase;
  int m_balls;
  int m_score;
  int m_wait;

  pong_game_ctrl #(
    .NUM_BALLS   (3),
    .TIMER_TICKS (120),
    .TIMER_W     (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .refr_tick   (refr_tick),
    .hit         (hit),
    .miss        (miss),
    .graph_still (graph_still),
    .text_mode   (text_mode),
    .balls_left  (balls_left),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       refr;
    int         mode;
    int         still;
    int         balls;
    int         d1;
    int         d0;
    int         over;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_balls = NB;
    m_score = 0;
    m_wait  = 0;
  endtask

  task automatic model_update(input logic [1:0] b, input logic h, input logic m, input logic r);
    bit pressed;
    bit done;
    int nwait;
    pressed = (b != 2'b00);
    done    = (m_wait == 0);
    nwait   = (r && m_wait > 0) ? m_wait - 1 : m_wait;
    case (m_phase)
      0: if (pressed) begin m_phase = 1; m_balls--; m_score = 0; end
      1: if (m) begin
           nwait   = TICKS - 1;
           m_phase = (m_balls == 0) ? 3 : 2;
         end else if (h) begin
           m_score = (m_score + 1) % 100;
         end
      2: if (done && pressed) begin m_phase = 1; m_balls--; end
      default: if (done) begin m_phase = 0; m_balls = NB; end
    endcase
    m_wait = nwait;
  endtask

  task automatic check_model();
    chk("text_mode", int'(text_mode), m_phase);
    chk("graph_still", int'(graph_still), (m_phase != 1) ? 1 : 0);
    chk("game_over", int'(game_over), (m_phase == 3) ? 1 : 0);
    chk("balls_left", int'(balls_left), m_balls);
    chk("score_d1", int'(score_d1), m_score / 10);
    chk("score_d0", int'(score_d0), m_score % 10);
  endtask

  task automatic expect_out(input string tag, input int mode, input int still, input int balls,
                            input int d1, input int d0, input int over);
    chk({tag, ".text_mode"}, int'(text_mode), mode);
    chk({tag, ".graph_still"}, int'(graph_still), still);
    chk({tag, ".balls_left"}, int'(balls_left), balls);
    chk({tag, ".score_d1"}, int'(score_d1), d1);
    chk({tag, ".score_d0"}, int'(score_d0), d0);
    chk({tag, ".game_over"}, int'(game_over), over);
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic step(input logic [1:0] b, input logic h, input logic m, input logic r);
    btn = b; hit = h; miss = m; refr_tick = r;
    @(posedge clk);
    model_update(b, h, m, r);
    #1;
    check_model();
  endtask

  // n refresh ticks, one every fourth clock, button held at b; returns right after the last tick.
  task automatic run_ticks(input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) step(b, 1'b0, 1'b0, 1'b0);
      step(b, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic apply_reset();
    btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_model();
    @(posedge clk);
    #1 check_model();
    #2 reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 0, 1, 3, 0, 0, 0};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 1, 0, 2, 0, 0, 0};
    vecs[2] = '{2'b00, 1'b1, 1'b0, 1'b1, 1, 0, 2, 0, 1, 0};
    vecs[3] = '{2'b00, 1'b1, 1'b0, 1'b0, 1, 0, 2, 0, 2, 0};
    vecs[4] = '{2'b00, 1'b1, 1'b1, 1'b0, 2, 1, 2, 0, 2, 0};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b1, 2, 1, 2, 0, 2, 0};
    vecs[6] = '{2'b00, 1'b0, 1'b1, 1'b0, 2, 1, 2, 0, 2, 0};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b1, 2, 1, 2, 0, 2, 0};

    btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    reset = 1'b1;
    model_reset();
    #3 expect_out("por", 0, 1, 3, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle title screen.
    for (int i = 0; i < 100; i++) step(2'b00, 1'b0, 1'b0, 1'b0);
    expect_out("title", 0, 1, 3, 0, 0, 0);

    // Serve.
    step(2'b01, 1'b0, 1'b0, 1'b0);
    expect_out("serve", 1, 0, 2, 0, 0, 0);
    step(2'b00, 1'b0, 1'b0, 1'b0);

    // Score counting and BCD boundaries.
    for (int i = 0; i < 12; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
    expect_out("score12", 1, 0, 2, 1, 2, 0);
    for (int i = 0; i < 87; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
    expect_out("score99", 1, 0, 2, 9, 9, 0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    expect_out("wrap00", 1, 0, 2, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
    expect_out("score09", 1, 0, 2, 0, 9, 0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    expect_out("carry10", 1, 0, 2, 1, 0, 0);

    // hit+miss together: miss wins, no increment; go to new-ball wait.
    step(2'b00, 1'b1, 1'b1, 1'b0);
    expect_out("hitmiss", 2, 1, 2, 1, 0, 0);

    // Button held through the wait is accepted only once the timer expires.
    run_ticks(118, 2'b01);
    expect_out("wait118", 2, 1, 2, 1, 0, 0);
    run_ticks(1, 2'b01);
    expect_out("wait119", 2, 1, 2, 1, 0, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    expect_out("reserve", 1, 0, 1, 1, 0, 0);

    // Second ball lost, third ball served, last ball lost -> game over.
    step(2'b00, 1'b0, 1'b1, 1'b0);
    expect_out("miss2", 2, 1, 1, 1, 0, 0);
    run_ticks(119, 2'b00);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    expect_out("serve3", 1, 0, 0, 1, 0, 0);
    step(2'b00, 1'b1, 1'b1, 1'b1);
    expect_out("over", 3, 1, 0, 1, 0, 1);
    run_ticks(118, 2'b00);
    expect_out("over118", 3, 1, 0, 1, 0, 1);
    run_ticks(1, 2'b00);
    expect_out("over119", 3, 1, 0, 1, 0, 1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    expect_out("newgame", 0, 1, 3, 1, 0, 0);

    // New game clears score; reset in the new-ball wait restores everything.
    step(2'b11, 1'b0, 1'b0, 1'b0);
    expect_out("start2", 1, 0, 2, 0, 0, 0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    expect_out("wait2", 2, 1, 2, 0, 1, 0);
    apply_reset();
    expect_out("midreset", 0, 1, 3, 0, 0, 0);

    // Table-driven vectors from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].btn, vecs[i].hit, vecs[i].miss, vecs[i].refr);
      expect_out($sformatf("vec%0d", i), vecs[i].mode, vecs[i].still, vecs[i].balls,
                 vecs[i].d1, vecs[i].d0, vecs[i].over);
    end

    // Randomized play against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        apply_reset();
      end else begin
        step(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
